// File: rtl/ca_pkg.sv
// Shared types and helpers for the cellular-automaton state engine.
package ca_pkg;

  localparam int GEN_W = 16;

  typedef enum logic {
    CA_IDLE = 1'b0,
    CA_RUN  = 1'b1
  } ca_fsm_e;

  // Wolfram rule table: neighbourhood {L,C,R} read MSB-first selects the output bit.
  function automatic logic rule_lookup(input logic [7:0] rule, input logic l,
                                       input logic c, input logic r);
    return rule[{l, c, r}];
  endfunction

endpackage

// File: rtl/ca_next_gen.sv
// Combinational one-generation step of a 1-D elementary CA.
// Boundary: CA_WRAP_EN defined -> toroidal, otherwise edge neighbours read as 0.
import ca_pkg::*;

module ca_next_gen #(
  parameter int CELLS = 64
) (
  input  logic [CELLS-1:0] state,
  input  logic [7:0]       rule,
  output logic [CELLS-1:0] next
);

  // ext[i+1] holds cell i; ext[CELLS+1] and ext[0] are the out-of-range neighbours.
  logic [CELLS+1:0] ext;

`ifdef CA_WRAP_EN
  assign ext = {state[0], state, state[CELLS-1]};
`else
  assign ext = {1'b0, state, 1'b0};
`endif

  for (genvar i = 0; i < CELLS; i++) begin : g_cell
    assign next[i] = rule_lookup(rule, ext[i+2], ext[i+1], ext[i]);
  end

endmodule

// File: rtl/ca_state_engine.sv
// CA state register with paged writes, LED page mirror and single-step/free-run stepping.
// Boundary mode selected by CA_WRAP_EN inside ca_next_gen.
import ca_pkg::*;

module ca_state_engine #(
  parameter int CELLS    = 64,
  parameter int PAGE_W   = 16,
  parameter int TICK_DIV = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [$clog2(CELLS/PAGE_W)-1:0] page_sel,
  input  logic                            load,
  input  logic [PAGE_W-1:0]               din,
  input  logic [7:0]                      rule,
  input  logic                            run,
  input  logic                            step,
  output logic [PAGE_W-1:0]               led,
  output logic [CELLS-1:0]                state,
  output logic [GEN_W-1:0]                gen_count,
  output logic                            frozen
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  ca_fsm_e          fsm;
  logic [TW-1:0]    tick;
  logic             load_q, step_q;
  logic             wr, step_ev, tick_hit, gen;
  logic [CELLS-1:0] next, state_nxt;

  ca_next_gen #(.CELLS(CELLS)) u_next_gen (
    .state (state),
    .rule  (rule),
    .next  (next)
  );

  assign wr       = load & ~load_q;
  assign step_ev  = step & ~step_q & (fsm == CA_IDLE);
  assign tick_hit = (fsm == CA_RUN) && (tick == TW'(TICK_DIV - 1));
  // A write always wins over a generation landing on the same edge.
  assign gen      = ~wr & (step_ev | tick_hit);

  always_comb begin
    state_nxt = state;
    if (wr)
      state_nxt[page_sel*PAGE_W +: PAGE_W] = din;
    else if (gen)
      state_nxt = next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= CA_IDLE;
      tick      <= '0;
      load_q    <= 1'b0;
      step_q    <= 1'b0;
      state     <= '0;
      led       <= '0;
      gen_count <= '0;
      frozen    <= 1'b0;
    end else begin
      load_q <= load;
      step_q <= step;
      state  <= state_nxt;
      led    <= state_nxt[page_sel*PAGE_W +: PAGE_W];

      if (wr) begin
        gen_count <= '0;
        frozen    <= 1'b0;
      end else if (gen) begin
        gen_count <= gen_count + GEN_W'(1);
        frozen    <= (next == state);
      end

      case (fsm)
        CA_IDLE: if (run)  fsm <= CA_RUN;
        CA_RUN:  if (!run) fsm <= CA_IDLE;
        default: fsm <= CA_IDLE;
      endcase

      // Counter only advances while staying in RUN; any exit, write or fire restarts it.
      if (fsm == CA_RUN && run && !wr && !tick_hit)
        tick <= tick + TW'(1);
      else
        tick <= '0;
    end
  end

endmodule

// File: tb/tb_ca_state_engine.sv
// Randomised self-checking bench for ca_state_engine against a behavioural CA model.
module tb_ca_state_engine;

  localparam int CELLS = 64, PAGE_W = 16, TICK_DIV = 4;
`ifdef CA_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        clk, rst_n;
  logic [1:0]  page_sel;
  logic        load, run, step;
  logic [15:0] din;
  logic [7:0]  rule;
  logic [15:0] led;
  logic [63:0] state;
  logic [15:0] gen_count;
  logic        frozen;

  ca_state_engine #(.CELLS(CELLS), .PAGE_W(PAGE_W), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .page_sel(page_sel), .load(load), .din(din),
    .rule(rule), .run(run), .step(step), .led(led), .state(state),
    .gen_count(gen_count), .frozen(frozen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0, n_total = 0;

  // Reference model: plain bookkeeping of what the block should hold.
  logic [63:0] m_state;
  logic [15:0] m_led, m_gen;
  logic        m_frozen, m_running, m_load_prev, m_step_prev;
  int          m_since;

  function automatic logic [63:0] ref_gen(input logic [63:0] s, input logic [7:0] r);
    logic [63:0] n;
    for (int i = 0; i < 64; i++) begin
      int l, c, rr;
      l  = (i == 63) ? (WRAP ? int'(s[0])  : 0) : int'(s[i+1]);
      c  = int'(s[i]);
      rr = (i == 0)  ? (WRAP ? int'(s[63]) : 0) : int'(s[i-1]);
      n[i] = r[l*4 + c*2 + rr];
    end
    return n;
  endfunction

  task automatic model_reset();
    m_state = '0; m_led = '0; m_gen = '0; m_frozen = 1'b0;
    m_running = 1'b0; m_load_prev = 1'b0; m_step_prev = 1'b0; m_since = 0;
  endtask

  task automatic model_edge();
    bit wr, stp, fire;
    logic [63:0] n;
    wr   = load && !m_load_prev;
    stp  = step && !m_step_prev && !m_running;
    fire = 1'b0;
    if (m_running) begin
      m_since++;
      if (m_since == TICK_DIV) begin
        fire = 1'b1;
        m_since = 0;
      end
    end
    if (wr) begin
      m_state[int'(page_sel)*16 +: 16] = din;
      m_gen = 0; m_frozen = 1'b0;
      m_since = 0;
    end else if (fire || stp) begin
      n = ref_gen(m_state, rule);
      m_frozen = (n == m_state);
      m_state = n;
      m_gen = m_gen + 16'd1;
    end
    m_led = m_state[int'(page_sel)*16 +: 16];
    if (m_running && !run) m_running = 1'b0;
    else if (!m_running && run) begin
      m_running = 1'b1;
      m_since = 0;
    end
    m_load_prev = load;
    m_step_prev = step;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_edge(); else model_reset();
    #1;
  endtask

  task automatic write_page(input logic [1:0] p, input logic [15:0] d);
    page_sel = p; din = d; load = 1'b1; cyc();
    load = 1'b0; cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      page_sel = 2'($urandom); load = 1'($urandom); din = 16'($urandom);
      rule = 8'($urandom); run = 1'($urandom); step = 1'($urandom);
      @(posedge clk); #1;
    end
    n_total++; if (state !== 64'h0) $display("FAIL reset_state got=%h exp=0", state); else n_pass++;
    n_total++; if (led !== 16'h0) $display("FAIL reset_led got=%h exp=0", led); else n_pass++;
    n_total++; if (gen_count !== 16'h0) $display("FAIL reset_gen got=%0d exp=0", gen_count); else n_pass++;
    n_total++; if (frozen !== 1'b0) $display("FAIL reset_frozen got=%b exp=0", frozen); else n_pass++;
    page_sel = 0; load = 0; din = 0; rule = 8'd90; run = 0; step = 0;
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    n_total++; if (state !== 64'h0 || gen_count !== 16'h0)
      $display("FAIL reset_idle got state=%h gen=%0d exp 0/0", state, gen_count); else n_pass++;
  endtask

  task automatic test_page_write();
    page_sel = 2'd2; din = 16'hBEEF; load = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    n_total++; if (state !== 64'h0000_BEEF_0000_0000)
      $display("FAIL write_state got=%h exp=0000beef00000000", state); else n_pass++;
    n_total++; if (led !== 16'hBEEF) $display("FAIL write_led got=%h exp=beef", led); else n_pass++;
    // A second distinct din while still held must not be written.
    din = 16'h1234; cyc();
    n_total++; if (state !== m_state) $display("FAIL write_once got=%h exp=%h", state, m_state); else n_pass++;
    load = 1'b0; page_sel = 2'd0; cyc();
    n_total++; if (led !== 16'h0) $display("FAIL led_follow got=%h exp=0", led); else n_pass++;
  endtask

  task automatic test_step();
    write_page(0, 0); write_page(1, 0); write_page(3, 0); write_page(2, 16'h0001);
    rule = 8'd90; step = 1'b1; cyc(); step = 1'b0; cyc();
    n_total++; if (state !== ((64'h1 << 33) | (64'h1 << 31)))
      $display("FAIL step_state got=%h exp=%h", state, (64'h1 << 33) | (64'h1 << 31)); else n_pass++;
    n_total++; if (gen_count !== 16'd1) $display("FAIL step_gen got=%0d exp=1", gen_count); else n_pass++;
    n_total++; if (frozen !== 1'b0) $display("FAIL step_frozen got=%b exp=0", frozen); else n_pass++;
    run = 1'b1; cyc(); step = 1'b1; cyc(); step = 1'b0; run = 1'b0; cyc(); cyc();
    n_total++; if (gen_count !== 16'd1 || state !== m_state)
      $display("FAIL step_in_run got gen=%0d state=%h exp gen=1 state=%h", gen_count, state, m_state); else n_pass++;
  endtask

  task automatic test_boundary();
    logic [63:0] exp;
    write_page(0, 0); write_page(1, 0); write_page(2, 0); write_page(3, 16'h8000);
    rule = 8'd90; step = 1'b1; cyc(); step = 1'b0; cyc();
    exp = WRAP ? ((64'h1 << 62) | 64'h1) : (64'h1 << 62);
    n_total++; if (state !== exp) $display("FAIL boundary got=%h exp=%h", state, exp); else n_pass++;
  endtask

  task automatic test_run_and_collision();
    logic [15:0] d;
    write_page(1, 16'hA5C3);
    rule = 8'd204; run = 1'b1; cyc();
    for (int k = 1; k <= 12; k++) begin
      cyc();
      n_total++; if (gen_count !== 16'(k / 4))
        $display("FAIL run_gen k=%0d got=%0d exp=%0d", k, gen_count, k / 4); else n_pass++;
      n_total++; if (frozen !== (k >= 4))
        $display("FAIL run_frozen k=%0d got=%b exp=%b", k, frozen, k >= 4); else n_pass++;
    end
    n_total++; if (state !== m_state) $display("FAIL run_state got=%h exp=%h", state, m_state); else n_pass++;
    // Next tick is the 4th edge from here; land a write on it.
    cyc(); cyc(); cyc();
    d = 16'($urandom) | 16'h1; page_sel = 2'd1; din = d; load = 1'b1; cyc(); load = 1'b0;
    n_total++; if (gen_count !== 16'd0) $display("FAIL coll_gen got=%0d exp=0", gen_count); else n_pass++;
    n_total++; if (state[31:16] !== d) $display("FAIL coll_write got=%h exp=%h", state[31:16], d); else n_pass++;
    cyc(); cyc(); cyc();
    n_total++; if (gen_count !== 16'd0) $display("FAIL coll_hold got=%0d exp=0", gen_count); else n_pass++;
    cyc();
    n_total++; if (gen_count !== 16'd1) $display("FAIL coll_next got=%0d exp=1", gen_count); else n_pass++;
    // Asynchronous reset mid-run, away from any clock edge.
    #2 rst_n = 1'b0; #1;
    model_reset();
    n_total++; if (state !== 64'h0 || led !== 16'h0 || gen_count !== 16'h0 || frozen !== 1'b0)
      $display("FAIL async_reset got state=%h led=%h gen=%0d frz=%b exp all 0", state, led, gen_count, frozen);
    else n_pass++;
    run = 1'b0; #2 rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      page_sel = 2'($urandom); din = 16'($urandom); rule = 8'($urandom);
      load = ($urandom_range(0, 3) == 0); step = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) run = ~run;
      cyc();
      n_total++; if (state !== m_state)
        $display("FAIL rnd_state i=%0d got=%h exp=%h", i, state, m_state); else n_pass++;
      n_total++; if (led !== m_led)
        $display("FAIL rnd_led i=%0d got=%h exp=%h", i, led, m_led); else n_pass++;
      n_total++; if (gen_count !== m_gen)
        $display("FAIL rnd_gen i=%0d got=%0d exp=%0d", i, gen_count, m_gen); else n_pass++;
      n_total++; if (frozen !== m_frozen)
        $display("FAIL rnd_frozen i=%0d got=%b exp=%b", i, frozen, m_frozen); else n_pass++;
    end
  endtask

  initial begin
    page_sel = 0; load = 0; din = 0; rule = 0; run = 0; step = 0; rst_n = 1'b0;
    test_reset();
    test_page_write();
    test_step();
    test_boundary();
    test_run_and_collision();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ca_state_engine.md
# ca_state_engine

Parametrised cellular-automaton state register with an integrated generation stepper. Software-visible seed data is written one page at a time from switch-style inputs, the selected page is mirrored on the LED bank, and a 1-D elementary CA rule (Wolfram 0-255) advances the whole state either one generation per step request or free-running at a programmable rate. It sits between the board I/O and the display/readout logic and owns the authoritative CA state.

## Interface
Parameters:
- CELLS, 64: number of cells; a multiple of PAGE_W.
- PAGE_W, 16: bits written/displayed per page. PAGES = CELLS/PAGE_W.
- TICK_DIV, 1: clock cycles per generation in run mode; must be >= 1.

Ports:
- clk  in  1  system clock; all state is updated on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- page_sel  in  $clog2(PAGES)  page index for writes and LED display; page p covers state[p*PAGE_W +: PAGE_W].
- load  in  1  write request; level input, rising-edge detected internally.
- din  in  PAGE_W  page write data.
- rule  in  8  Wolfram rule number, sampled at every generation update.
- run  in  1  level; 1 = free-run mode.
- step  in  1  single-generation request; level input, rising-edge detected, honoured only in IDLE.
- led  out  PAGE_W  registered copy of the selected page.
- state  out  CELLS  current CA state; bit CELLS-1 is leftmost.
- gen_count  out  16  generations since the last load; wraps 16'hFFFF -> 0.
- frozen  out  1  last generation produced no change.

## Operation
- FSM states are IDLE and RUN. IDLE -> RUN when run=1; RUN -> IDLE when run=0, with the tick counter cleared.
- Edge detect: load_q and step_q are registered copies. A write occurs on the cycle where load=1 and load_q=0; a step occurs on the cycle where step=1, step_q=0, and the FSM is in IDLE.
- Write: state[page_sel page] <= din, other pages unchanged, gen_count <= 0, frozen <= 0, tick counter <= 0.
- Generation: next[i] = rule[{L,C,R}], with L=state[i+1], C=state[i], R=state[i-1], and the 3-bit index MSB-first.
- Generation bookkeeping: gen_count += 1; frozen <= (next == state).
- RUN tick counter: counts 0..TICK_DIV-1. A generation fires on the cycle where the counter equals TICK_DIV-1, then the counter returns to 0.
- Priority when events coincide: write > generation. A write on a tick cycle suppresses that generation and restarts the counter.
- A step edge seen while in RUN is discarded.
- led <= page_sel page of the post-update state value. led therefore reflects a write or a generation on the same edge that state changes.

## Timing
- Reset (asynchronous): state=0, led=0, gen_count=0, frozen=0, FSM=IDLE, tick counter=0, load_q=0, step_q=0.
- Reset asserted mid-run clears everything immediately. After release the block is in IDLE; it enters RUN on the first clock edge at which run=1.
- Write latency: the load rising edge is sampled at edge N and state/led are updated at edge N. Holding load high for any number of cycles writes exactly once.
- page_sel change: led follows at the next edge.
- Step latency: one edge from sampling the step edge.
- Run rate: the first generation fires TICK_DIV edges after entering RUN, then one every TICK_DIV edges.
- Each generation update is a single cycle, fully combinational from state. There is no pipelining.

## Configuration
- CA_WRAP_EN defined: toroidal boundary. Cell CELLS-1's left neighbour is cell 0; cell 0's right neighbour is cell CELLS-1.
- CA_WRAP_EN undefined: out-of-range neighbours read as 0.

## Structure
- Package ca_pkg holds:
  - the FSM enum (CA_IDLE, CA_RUN);
  - the gen_count width constant GEN_W = 16;
  - a function rule_lookup(rule, L, C, R).
- Sub-module ca_next_gen (parameter CELLS) is purely combinational: state and rule in, next out. The CA_WRAP_EN boundary handling lives inside it.
- ca_state_engine holds the FSM, edge detectors, tick counter, page write, and registered outputs.

## Test plan
All scenarios use CELLS=64, PAGE_W=16, TICK_DIV=4 unless noted.
1. Reset: hold rst_n=0 with random inputs -> state=0, led=0, gen_count=0, frozen=0. Release with run=0 -> remains IDLE.
2. Page write: page_sel=2, din=16'hBEEF, load held high 5 cycles -> state[47:32]=16'hBEEF (single write), led=16'hBEEF, other bits 0. Then page_sel=0 -> led=0 next edge.
3. Step: state=1<<32, rule=90, one step pulse -> state = (1<<33)|(1<<31), gen_count=1, frozen=0. A step pulse while run=1 -> ignored.
4. Boundary: state=1<<63, rule=90, step -> with CA_WRAP_EN: bits 62 and 0 set. Without CA_WRAP_EN: only bit 62 set.
5. Run: nonzero state, rule=204 (identity), run=1 for 12 cycles -> gen_count increments at cycles 4, 8, 12; frozen=1 after the first generation.
6. Collisions:
   - In RUN, load edge on a tick cycle -> write applied, no generation, gen_count=0, next generation 4 cycles later.
   - rst_n pulsed low mid-run -> all outputs 0 asynchronously.
